// File: rtl/decode_pipe_stage_if.sv
// Bundle of the decode stage's handshake and data signals. The fetch/execute side
// (or a testbench) uses the master modport, the decode stage uses the slave modport.
interface decode_pipe_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int PC_W   = 16
);
  // Fetch side
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [PC_W-1:0]   in_pc2;

  // Register file read ports (asynchronous read, external array)
  logic [REG_AW-1:0] rf_rs_addr;
  logic [REG_AW-1:0] rf_rt_addr;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;

  // Execute side
  logic              flush;
  logic              ex_ready;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc2;
  logic [REG_AW-1:0] out_rd;
  logic [DATA_W-1:0] out_rs_data;
  logic [DATA_W-1:0] out_rt_data;
  logic [DATA_W-1:0] out_imm;
  logic [3:0]        out_alu_op;
  logic              out_mem_rd;
  logic              out_mem_wr;
  logic              out_reg_wr;
  logic [1:0]        out_wb_src;
  logic [1:0]        out_br_type;
  logic [2:0]        out_br_cond;
  logic              out_halt;
  logic              halted;

  modport master (
    output in_valid, in_instr, in_pc2, rf_rs_data, rf_rt_data, flush, ex_ready,
    input  in_ready, rf_rs_addr, rf_rt_addr, out_valid, out_pc2, out_rd,
           out_rs_data, out_rt_data, out_imm, out_alu_op, out_mem_rd, out_mem_wr,
           out_reg_wr, out_wb_src, out_br_type, out_br_cond, out_halt, halted
  );

  modport slave (
    input  in_valid, in_instr, in_pc2, rf_rs_data, rf_rt_data, flush, ex_ready,
    output in_ready, rf_rs_addr, rf_rt_addr, out_valid, out_pc2, out_rd,
           out_rs_data, out_rt_data, out_imm, out_alu_op, out_mem_rd, out_mem_wr,
           out_reg_wr, out_wb_src, out_br_type, out_br_cond, out_halt, halted
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// Decode stage: turns one 16-bit instruction per cycle into a registered ID/EX bundle.
// Handles load-use stalls (one bubble), flush from execute and a sticky halted state.
module decode_pipe_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int PC_W   = 16
) (
  input logic              clk,
  input logic              rst,
  decode_pipe_stage_if.slave bus
);

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC2 = 2'd2;
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_IMM  = 2'd1;
  localparam logic [1:0] BR_REG  = 2'd2;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  // Immediate and register-address extension helpers
  function automatic logic [DATA_W-1:0] sext4_x2(input logic [3:0] f);
    return {{(DATA_W-5){f[3]}}, f, 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] sext9_x2(input logic [8:0] f);
    return {{(DATA_W-10){f[8]}}, f, 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] zext4(input logic [3:0] f);
    return {{(DATA_W-4){1'b0}}, f};
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] f);
    return {{(DATA_W-8){1'b0}}, f};
  endfunction

  function automatic logic [REG_AW-1:0] zext_reg(input logic [3:0] f);
    logic [REG_AW-1:0] r;
    r      = {REG_AW{1'b0}};
    r[3:0] = f;
    return r;
  endfunction

  logic [3:0]        opcode;
  logic [3:0]        rs_field;
  logic [3:0]        rt_field;
  logic              rs_used;
  logic              rt_used;
  logic              wr_en;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_d;
  logic [DATA_W-1:0] imm_d;
  logic [3:0]        alu_op_d;
  logic              mem_rd_d;
  logic              mem_wr_d;
  logic              reg_wr_d;
  logic [1:0]        wb_src_d;
  logic [1:0]        br_type_d;
  logic [2:0]        br_cond_d;
  logic              halt_d;

  state_t            state_q;
  logic              halted_q;
  logic              out_valid_q;
  logic [PC_W-1:0]   out_pc2_q;
  logic [REG_AW-1:0] out_rd_q;
  logic [DATA_W-1:0] out_rs_data_q;
  logic [DATA_W-1:0] out_rt_data_q;
  logic [DATA_W-1:0] out_imm_q;
  logic [3:0]        out_alu_op_q;
  logic              out_mem_rd_q;
  logic              out_mem_wr_q;
  logic              out_reg_wr_q;
  logic [1:0]        out_wb_src_q;
  logic [1:0]        out_br_type_q;
  logic [2:0]        out_br_cond_q;
  logic              out_halt_q;

  logic              hazard;
  logic              advance;
  logic              ready_core;
  logic              accept;

  assign opcode = bus.in_instr[15:12];

  // Instruction decode: operand fields, which sources are read, and the control bundle
  always_comb begin
    rs_field  = bus.in_instr[7:4];
    rt_field  = bus.in_instr[3:0];
    rs_used   = 1'b0;
    rt_used   = 1'b0;
    wr_en     = 1'b0;
    imm_d     = {DATA_W{1'b0}};
    alu_op_d  = opcode;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    wb_src_d  = WB_ALU;
    br_type_d = BR_NONE;
    br_cond_d = 3'd0;
    halt_d    = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
        wr_en   = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        rs_used = 1'b1;
        wr_en   = 1'b1;
        imm_d   = zext4(bus.in_instr[3:0]);
      end
      OP_LW: begin
        rs_used  = 1'b1;
        wr_en    = 1'b1;
        alu_op_d = OP_ADD;
        mem_rd_d = 1'b1;
        wb_src_d = WB_MEM;
        imm_d    = sext4_x2(bus.in_instr[3:0]);
      end
      OP_SW: begin
        // Store data register sits in the rd slot
        rt_field = bus.in_instr[11:8];
        rs_used  = 1'b1;
        rt_used  = 1'b1;
        alu_op_d = OP_ADD;
        mem_wr_d = 1'b1;
        imm_d    = sext4_x2(bus.in_instr[3:0]);
      end
      OP_LLB, OP_LHB: begin
        // Byte loads merge into the existing destination value
        rs_field = bus.in_instr[11:8];
        rs_used  = 1'b1;
        wr_en    = 1'b1;
        imm_d    = zext8(bus.in_instr[7:0]);
      end
      OP_B: begin
        br_type_d = BR_IMM;
        br_cond_d = bus.in_instr[11:9];
        imm_d     = sext9_x2(bus.in_instr[8:0]);
      end
      OP_BR: begin
        rs_used   = 1'b1;
        br_type_d = BR_REG;
        br_cond_d = bus.in_instr[11:9];
      end
      OP_PCS: begin
        wr_en    = 1'b1;
        wb_src_d = WB_PC2;
      end
      OP_HLT: begin
        halt_d = 1'b1;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
    rs_addr  = zext_reg(rs_field);
    rt_addr  = zext_reg(rt_field);
    rd_d     = zext_reg(bus.in_instr[11:8]);
    reg_wr_d = wr_en & (rd_d != {REG_AW{1'b0}});
  end

  // Load-use detection against the bundle currently held for execute
  always_comb begin
    if (out_valid_q && out_mem_rd_q && (out_rd_q != {REG_AW{1'b0}})) begin
      hazard = (rs_used && (out_rd_q == rs_addr)) || (rt_used && (out_rd_q == rt_addr));
    end else begin
      hazard = 1'b0;
    end
  end

  assign advance    = !out_valid_q || bus.ex_ready;
  assign ready_core = (state_q == ST_RUN) && advance && !hazard && !bus.flush;
  assign accept     = bus.in_valid && ready_core;

  // FSM and ID/EX bundle: flush beats advance, stall holds everything stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      halted_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_pc2_q     <= {PC_W{1'b0}};
      out_rd_q      <= {REG_AW{1'b0}};
      out_rs_data_q <= {DATA_W{1'b0}};
      out_rt_data_q <= {DATA_W{1'b0}};
      out_imm_q     <= {DATA_W{1'b0}};
      out_alu_op_q  <= 4'd0;
      out_mem_rd_q  <= 1'b0;
      out_mem_wr_q  <= 1'b0;
      out_reg_wr_q  <= 1'b0;
      out_wb_src_q  <= 2'd0;
      out_br_type_q <= 2'd0;
      out_br_cond_q <= 3'd0;
      out_halt_q    <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= ST_RUN;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        out_valid_q   <= 1'b1;
        out_pc2_q     <= bus.in_pc2;
        out_rd_q      <= rd_d;
        out_rs_data_q <= bus.rf_rs_data;
        out_rt_data_q <= bus.rf_rt_data;
        out_imm_q     <= imm_d;
        out_alu_op_q  <= alu_op_d;
        out_mem_rd_q  <= mem_rd_d;
        out_mem_wr_q  <= mem_wr_d;
        out_reg_wr_q  <= reg_wr_d;
        out_wb_src_q  <= wb_src_d;
        out_br_type_q <= br_type_d;
        out_br_cond_q <= br_cond_d;
        out_halt_q    <= halt_d;
        if (halt_d) begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // in_ready is forced low while reset is applied
  assign bus.in_ready    = !rst && ready_core;
  assign bus.rf_rs_addr  = rs_addr;
  assign bus.rf_rt_addr  = rt_addr;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc2     = out_pc2_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_rs_data = out_rs_data_q;
  assign bus.out_rt_data = out_rt_data_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_alu_op  = out_alu_op_q;
  assign bus.out_mem_rd  = out_mem_rd_q;
  assign bus.out_mem_wr  = out_mem_wr_q;
  assign bus.out_reg_wr  = out_reg_wr_q;
  assign bus.out_wb_src  = out_wb_src_q;
  assign bus.out_br_type = out_br_type_q;
  assign bus.out_br_cond = out_br_cond_q;
  assign bus.out_halt    = out_halt_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Self-checking bench for decode_pipe_stage: directed scenarios followed by random
// traffic, all compared against an instruction-level reference model.
module tb_decode_pipe_stage;

  typedef struct packed {
    logic [15:0] pc2;
    logic [3:0]  rd;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic [1:0]  wb_src;
    logic [1:0]  br_type;
    logic [2:0]  br_cond;
    logic        halt;
  } bundle_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic    m_valid;
  logic    m_halted;
  bundle_t m_b;

  decode_pipe_stage_if #(.DATA_W(16), .REG_AW(4), .PC_W(16)) bus ();

  decode_pipe_stage #(.DATA_W(16), .REG_AW(4), .PC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t dut_bundle();
    return {bus.out_pc2, bus.out_rd, bus.out_rs_data, bus.out_rt_data, bus.out_imm,
            bus.out_alu_op, bus.out_mem_rd, bus.out_mem_wr, bus.out_reg_wr,
            bus.out_wb_src, bus.out_br_type, bus.out_br_cond, bus.out_halt};
  endfunction

  // Reference decode written from the ISA table with plain integer arithmetic
  function automatic bundle_t ref_dec(input logic [15:0] ins, input logic [15:0] pc2,
                                      input logic [15:0] rsd, input logic [15:0] rtd);
    bundle_t b;
    int op;
    int v;
    op        = int'(ins[15:12]);
    b         = '0;
    b.pc2     = pc2;
    b.rd      = ins[11:8];
    b.rs_data = rsd;
    b.rt_data = rtd;
    b.alu_op  = (op == 8 || op == 9) ? 4'd0 : ins[15:12];
    b.mem_rd  = (op == 8);
    b.mem_wr  = (op == 9);
    b.reg_wr  = (op <= 8 || op == 10 || op == 11 || op == 14) && (ins[11:8] != 4'd0);
    b.wb_src  = (op == 8) ? 2'd1 : ((op == 14) ? 2'd2 : 2'd0);
    b.br_type = (op == 12) ? 2'd1 : ((op == 13) ? 2'd2 : 2'd0);
    b.br_cond = (op == 12 || op == 13) ? ins[11:9] : 3'd0;
    b.halt    = (op == 15);
    v = 0;
    if (op == 8 || op == 9) begin
      v = int'(ins[3:0]);
      if (v > 7) v = v - 16;
      v = v * 2;
    end else if (op >= 4 && op <= 6) begin
      v = int'(ins[3:0]);
    end else if (op == 10 || op == 11) begin
      v = int'(ins[7:0]);
    end else if (op == 12) begin
      v = int'(ins[8:0]);
      if (v > 255) v = v - 512;
      v = v * 2;
    end
    b.imm = 16'(v);
    return b;
  endfunction

  // True when ins reads the register the held load is about to write
  function automatic logic ref_hazard(input logic [15:0] ins);
    logic [3:0] srcs[$];
    int op;
    op = int'(ins[15:12]);
    if (!(m_valid && m_b.mem_rd && m_b.rd != 4'd0)) return 1'b0;
    if (op <= 3 || op == 7) begin
      srcs.push_back(ins[7:4]);
      srcs.push_back(ins[3:0]);
    end else if ((op >= 4 && op <= 6) || op == 8 || op == 13) begin
      srcs.push_back(ins[7:4]);
    end else if (op == 9) begin
      srcs.push_back(ins[7:4]);
      srcs.push_back(ins[11:8]);
    end else if (op == 10 || op == 11) begin
      srcs.push_back(ins[11:8]);
    end
    foreach (srcs[i]) if (srcs[i] == m_b.rd) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(m_valid));
    chk({tag, ".halted"}, 128'(bus.halted), 128'(m_halted));
    if (m_valid) chk({tag, ".bundle"}, 128'(dut_bundle()), 128'(m_b));
  endtask

  // One clock of stimulus with checks of the combinational and registered outputs
  task automatic step(input logic v, input logic [15:0] ins, input logic fl, input logic exr);
    logic [15:0] pc2;
    logic [15:0] rsd;
    logic [15:0] rtd;
    logic        exp_rdy;
    logic        acc;
    int          op;
    @(negedge clk);
    pc2 = 16'($urandom);
    rsd = 16'($urandom);
    rtd = 16'($urandom);
    bus.in_valid   = v;
    bus.in_instr   = ins;
    bus.in_pc2     = pc2;
    bus.rf_rs_data = rsd;
    bus.rf_rt_data = rtd;
    bus.flush      = fl;
    bus.ex_ready   = exr;
    #1;
    op = int'(ins[15:12]);
    exp_rdy = !rst && !m_halted && (!m_valid || exr) && !ref_hazard(ins) && !fl;
    chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
    chk("rf_rs_addr", 128'(bus.rf_rs_addr), 128'((op == 10 || op == 11) ? ins[11:8] : ins[7:4]));
    chk("rf_rt_addr", 128'(bus.rf_rt_addr), 128'((op == 9) ? ins[11:8] : ins[3:0]));
    acc = v && exp_rdy;
    @(posedge clk);
    if (fl) begin
      m_valid  = 1'b0;
      m_halted = 1'b0;
    end else if (!m_valid || exr) begin
      if (acc) begin
        m_b     = ref_dec(ins, pc2, rsd, rtd);
        m_valid = 1'b1;
        if (m_b.halt) m_halted = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_outputs("cycle");
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".in_ready"}, 128'(bus.in_ready), 128'(1'b0));
    chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(1'b0));
    chk({tag, ".halted"}, 128'(bus.halted), 128'(1'b0));
    chk({tag, ".bundle"}, 128'(dut_bundle()), 128'(0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_b      = '0;
    clk = 1'b0;
    rst = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_instr   = 16'h0312;
    bus.in_pc2     = 16'h0000;
    bus.rf_rs_data = 16'h0000;
    bus.rf_rt_data = 16'h0000;
    bus.flush      = 1'b0;
    bus.ex_ready   = 1'b1;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // ADD R3,R1,R2
    step(1'b1, 16'h0312, 1'b0, 1'b1);
    chk("add.alu_op", 128'(bus.out_alu_op), 128'(4'd0));
    chk("add.rd", 128'(bus.out_rd), 128'(4'd3));
    chk("add.reg_wr", 128'(bus.out_reg_wr), 128'(1'b1));
    chk("add.wb_src", 128'(bus.out_wb_src), 128'(2'd0));
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // LW R4,[R1+2] followed by dependent ADD R5,R4,R6
    step(1'b1, 16'h8411, 1'b0, 1'b1);
    chk("lw.imm", 128'(bus.out_imm), 128'(16'h0002));
    step(1'b1, 16'h0546, 1'b0, 1'b1);
    chk("loaduse.bubble", 128'(bus.out_valid), 128'(1'b0));
    step(1'b1, 16'h0546, 1'b0, 1'b1);
    chk("loaduse.add_rd", 128'(bus.out_rd), 128'(4'd5));

    // Back-pressure: bundle held for three cycles, nothing lost
    step(1'b1, 16'h1123, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h2456, 1'b0, 1'b0);
    chk("hold.rd", 128'(bus.out_rd), 128'(4'd1));
    step(1'b1, 16'h2456, 1'b0, 1'b1);
    chk("hold.next_rd", 128'(bus.out_rd), 128'(4'd4));

    // Writes to R0 are suppressed
    step(1'b1, 16'h0012, 1'b0, 1'b1);
    chk("r0.reg_wr", 128'(bus.out_reg_wr), 128'(1'b0));

    // B cond=3, offset -4
    step(1'b1, 16'hC7FC, 1'b0, 1'b1);
    chk("b.imm", 128'(bus.out_imm), 128'(16'hFFF8));
    chk("b.br_type", 128'(bus.out_br_type), 128'(2'd1));
    chk("b.br_cond", 128'(bus.out_br_cond), 128'(3'd3));

    // Flush while execute stalls and fetch presents an instruction
    step(1'b1, 16'h0312, 1'b0, 1'b1);
    step(1'b1, 16'h1123, 1'b1, 1'b0);
    chk("flush.out_valid", 128'(bus.out_valid), 128'(1'b0));

    // HLT is sticky until flush
    step(1'b1, 16'hF000, 1'b0, 1'b1);
    chk("hlt.out_halt", 128'(bus.out_halt), 128'(1'b1));
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0312, 1'b0, 1'b1);
    chk("hlt.halted", 128'(bus.halted), 128'(1'b1));
    step(1'b1, 16'h0312, 1'b1, 1'b1);
    chk("hlt.flush_clears", 128'(bus.halted), 128'(1'b0));
    step(1'b1, 16'h0312, 1'b0, 1'b1);

    // Asynchronous reset in the middle of traffic
    step(1'b1, 16'h8411, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    m_valid  = 1'b0;
    m_halted = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
